core_sequencer: RTL and testbench

Multi-cycle control FSM for the single-issue RV32 core. It sequences the shared datapath through fetch, decode, execute, memory and writeback, and drives the instruction and data memory handshakes. It consumes the decode flags produced from the held instruction register and produces all register and PC write enables. It also detects ecall, illegal instructions and memory timeouts, and parks the core in a sticky halt.

---
 rtl/core_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_core_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the RV32 core
//
// Optional feature macro: SEQ_INSTRET_EN (64-bit retired-instruction counter on instret).
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : leave IDLE and begin fetching
//   imem_req / imem_ready       : instruction fetch handshake
//   dmem_req / dmem_we / dmem_ready : data access handshake
//   mem_read .. instr_invalid   : decode flags from the held instruction register
//   branch_taken                : comparator result (EXEC/WB)
//   ir_we, mdr_we, rf_we, pc_we : datapath register write enables
//   pc_src                      : 0 pc+4, 1 branch, 2 JAL, 3 JALR
//   halted, illegal, bus_err    : sticky halt and its cause
//   state_o                     : current state (debug)
//   instret                     : retired instruction count (0 when feature disabled)
module core_sequencer #(
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_jalr,
    input  logic        is_final,
    input  logic        instr_invalid,
    input  logic        branch_taken,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state_o,
    output logic [63:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             cnt_inc;
    logic             timeout_hit;
    logic             set_illegal;

    // State register, wait counter and sticky halt causes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state <= state_d;
            // Counter restarts on every state change so each wait is timed on its own.
            if (state_d != state) begin
                wait_cnt <= '0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (timeout_hit) begin
                bus_err <= 1'b1;
            end
        end
    end

    // Next-state logic. A ready seen on the expiry cycle takes the normal path.
    always_comb begin
        state_d     = state;
        cnt_inc     = 1'b0;
        timeout_hit = 1'b0;
        set_illegal = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_DECODE;
                end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_DECODE: begin
                if (instr_invalid) begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end else if (is_final) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (mem_read || mem_write) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (TO_EN && (wait_cnt == TO_LAST)) begin
                    state_d     = S_HALT;
                    timeout_hit = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Output decode: Moore requests, Mealy latch strobes.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        mdr_we   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = 2'd0;
        halted   = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write;
                mdr_we   = dmem_ready & mem_read;
            end
            S_WB: begin
                // A store never writes the register file.
                rf_we = reg_write & ~mem_write;
                pc_we = 1'b1;
                if (is_jump && is_jalr) begin
                    pc_src = 2'd3;
                end else if (is_jump) begin
                    pc_src = 2'd2;
                end else if (is_branch && branch_taken) begin
                    pc_src = 2'd1;
                end else begin
                    pc_src = 2'd0;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state_o = state;

`ifdef SEQ_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (state == S_WB) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst, start;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic        mem_read, mem_write, reg_write, is_branch, is_jump, is_jalr;
    logic        is_final, instr_invalid, branch_taken;
    logic        ir_we, mdr_we, rf_we, pc_we, halted, illegal, bus_err;
    logic [1:0]  pc_src;
    logic [2:0]  state_o;
    logic [63:0] instret;

    core_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .is_branch(is_branch), .is_jump(is_jump), .is_jalr(is_jalr),
        .is_final(is_final), .instr_invalid(instr_invalid), .branch_taken(branch_taken),
        .ir_we(ir_we), .mdr_we(mdr_we), .rf_we(rf_we), .pc_we(pc_we), .pc_src(pc_src),
        .halted(halted), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rd, wr, rw, br, jp, jr, tk;
        int         fw, dw;
        bit         exp_rf;
        logic [1:0] exp_src;
    } vec_t;

    int      n_checks = 0;
    int      n_err    = 0;
    longint  exp_ret  = 0;
    bit      noisy    = 0;
    vec_t    tbl[10];

    function automatic vec_t mk(bit rd, bit wr, bit rw, bit br, bit jp, bit jr, bit tk,
                                int fw, int dw, bit rf, logic [1:0] src);
        vec_t v;
        v.rd = rd; v.wr = wr; v.rw = rw; v.br = br; v.jp = jp; v.jr = jr; v.tk = tk;
        v.fw = fw; v.dw = dw; v.exp_rf = rf; v.exp_src = src;
        return v;
    endfunction

    // Reference rules for writeback: jump kind first, then taken branch, else sequential.
    function automatic logic [1:0] model_src(bit jp, bit jr, bit br, bit tk);
        if (jp) return jr ? 2'd3 : 2'd2;
        if (br && tk) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [14:0] ev(int st, bit imr, bit irw, bit dmr, bit dmw, bit mdw,
                                       bit rfw, bit pcw, logic [1:0] src, bit h, bit il, bit be);
        logic [2:0] s3;
        s3 = 3'(st);
        return {s3, imr, irw, dmr, dmw, mdw, rfw, pcw, src, h, il, be};
    endfunction

    function automatic longint exp_instret();
`ifdef SEQ_INSTRET_EN
        return exp_ret;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are already applied; check away from the edge, then advance one cycle.
    task automatic cyc(input string name, input logic [14:0] e);
        #1;
        chk(name, {49'd0, state_o, imem_req, ir_we, dmem_req, dmem_we, mdr_we, rf_we, pc_we,
                   pc_src, halted, illegal, bus_err}, {49'd0, e});
        chk({name, "_instret"}, instret, exp_instret());
        @(negedge clk);
    endtask

    function automatic bit rbit();
        return noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic set_dec(input vec_t v);
        mem_read = v.rd; mem_write = v.wr; reg_write = v.rw; is_branch = v.br;
        is_jump = v.jp; is_jalr = v.jr; branch_taken = v.tk;
        is_final = 1'b0; instr_invalid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        set_dec(mk(0,0,0,0,0,0,0,0,0,0,2'd0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ret = 0;
        cyc("reset_idle", ev(0,0,0,0,0,0,0,0,2'd0,0,0,0));
        cyc("idle_hold", ev(0,0,0,0,0,0,0,0,2'd0,0,0,0));
        start = 1'b1;
        cyc("idle_start", ev(0,0,0,0,0,0,0,0,2'd0,0,0,0));
        start = 1'b0;
    endtask

    task automatic run_instr(input string tag, input vec_t v);
        set_dec(v);
        for (int i = 0; i <= v.fw; i++) begin
            imem_ready = (i == v.fw); dmem_ready = rbit(); start = rbit();
            cyc({tag, "_fetch"}, ev(1,1,(i == v.fw),0,0,0,0,0,2'd0,0,0,0));
        end
        imem_ready = rbit(); dmem_ready = rbit(); start = rbit();
        cyc({tag, "_decode"}, ev(2,0,0,0,0,0,0,0,2'd0,0,0,0));
        imem_ready = rbit(); dmem_ready = rbit(); start = rbit();
        cyc({tag, "_exec"}, ev(3,0,0,0,0,0,0,0,2'd0,0,0,0));
        if (v.rd || v.wr) begin
            for (int j = 0; j <= v.dw; j++) begin
                dmem_ready = (j == v.dw); imem_ready = rbit(); start = rbit();
                cyc({tag, "_mem"}, ev(4,0,0,1,v.wr,(v.rd && j == v.dw),0,0,2'd0,0,0,0));
            end
        end
        imem_ready = rbit(); dmem_ready = rbit(); start = rbit();
        cyc({tag, "_wb"}, ev(5,0,0,0,0,0,v.exp_rf,1,v.exp_src,0,0,0));
        exp_ret++;
    endtask

    task automatic halt_stays(input string tag, input bit il, input bit be);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
            cyc({tag, "_halt_hold"}, ev(6,0,0,0,0,0,0,0,2'd0,1,il,be));
        end
        start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic run_halt_decode(input string tag, input bit inv, input bit fin);
        set_dec(mk(0,0,1,0,0,0,0,0,0,0,2'd0));
        imem_ready = 1'b1;
        cyc({tag, "_fetch"}, ev(1,1,1,0,0,0,0,0,2'd0,0,0,0));
        imem_ready = 1'b0; instr_invalid = inv; is_final = fin;
        cyc({tag, "_decode"}, ev(2,0,0,0,0,0,0,0,2'd0,0,0,0));
        cyc({tag, "_halt"}, ev(6,0,0,0,0,0,0,0,2'd0,1,inv,0));
        halt_stays(tag, inv, 1'b0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = mk(0,0,1,0,0,0,0, 0,0, 1,2'd0); // ADD
        tbl[1] = mk(1,0,1,0,0,0,0, 1,3, 1,2'd0); // LW, data ready after 3 waits
        tbl[2] = mk(0,1,1,0,0,0,0, 0,0, 0,2'd0); // SW with stray reg_write
        tbl[3] = mk(0,0,0,1,0,0,1, 0,0, 0,2'd1); // BEQ taken
        tbl[4] = mk(0,0,0,1,0,0,0, 2,0, 0,2'd0); // BEQ not taken
        tbl[5] = mk(0,0,1,0,1,0,0, 0,0, 1,2'd2); // JAL
        tbl[6] = mk(0,0,1,0,1,1,0, 0,0, 1,2'd3); // JALR
        tbl[7] = mk(0,0,1,1,1,0,1, 0,0, 1,2'd2); // jump outranks taken branch
        tbl[8] = mk(0,0,1,0,0,0,0, 3,0, 1,2'd0); // fetch ready on expiry cycle
        tbl[9] = mk(0,1,0,0,0,0,0, 0,3, 0,2'd0); // store ready on expiry cycle

        do_reset();
        for (int i = 0; i < 10; i++) run_instr($sformatf("tbl%0d", i), tbl[i]);

        // Randomized instruction stream with noise on ignored inputs.
        noisy = 1;
        for (int i = 0; i < 60; i++) begin
            int m;
            m = $urandom_range(0, 2);
            v.rd = (m == 1); v.wr = (m == 2);
            v.rw = 1'($urandom_range(0, 1)); v.br = 1'($urandom_range(0, 1));
            v.jp = 1'($urandom_range(0, 1)); v.jr = 1'($urandom_range(0, 1));
            v.tk = 1'($urandom_range(0, 1));
            v.fw = $urandom_range(0, 3); v.dw = $urandom_range(0, 3);
            v.exp_rf  = v.rw && !v.wr;
            v.exp_src = model_src(v.jp, v.jr, v.br, v.tk);
            run_instr($sformatf("rnd%0d", i), v);
        end
        noisy = 0;

        // Fetch timeout: four FETCH cycles, then sticky bus-error halt.
        do_reset();
        for (int i = 0; i < 4; i++) cyc("fetch_to", ev(1,1,0,0,0,0,0,0,2'd0,0,0,0));
        cyc("fetch_to_halt", ev(6,0,0,0,0,0,0,0,2'd0,1,0,1));
        halt_stays("fetch_to", 1'b0, 1'b1);

        // Data timeout on a load.
        do_reset();
        set_dec(mk(1,0,1,0,0,0,0,0,0,0,2'd0));
        imem_ready = 1'b1;
        cyc("mem_to_fetch", ev(1,1,1,0,0,0,0,0,2'd0,0,0,0));
        imem_ready = 1'b0;
        cyc("mem_to_decode", ev(2,0,0,0,0,0,0,0,2'd0,0,0,0));
        cyc("mem_to_exec", ev(3,0,0,0,0,0,0,0,2'd0,0,0,0));
        for (int i = 0; i < 4; i++) cyc("mem_to_wait", ev(4,0,0,1,0,0,0,0,2'd0,0,0,0));
        cyc("mem_to_halt", ev(6,0,0,0,0,0,0,0,2'd0,1,0,1));
        halt_stays("mem_to", 1'b0, 1'b1);

        // Reset while fetching drops the request after the edge.
        do_reset();
        cyc("rst_fetch_pre", ev(1,1,0,0,0,0,0,0,2'd0,0,0,0));
        rst = 1'b1;
        cyc("rst_fetch_edge", ev(1,1,0,0,0,0,0,0,2'd0,0,0,0));
        exp_ret = 0;
        cyc("rst_fetch_post", ev(0,0,0,0,0,0,0,0,2'd0,0,0,0));
        rst = 1'b0;

        // Invalid outranks ecall.
        do_reset();
        run_halt_decode("inv_fin", 1'b1, 1'b1);

        // Three ADDs then ecall: retire count stops at 3.
        do_reset();
        for (int i = 0; i < 3; i++) run_instr($sformatf("add%0d", i), tbl[0]);
        run_halt_decode("ecall", 1'b0, 1'b1);
        chk("ecall_instret_final", instret, exp_instret());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
